// File: rtl/hack_mem_pkg.sv
// Shared definitions for the Hack data-memory stage: memory map, region decode, screen FIFO entry.
package hack_mem_pkg;

  localparam int unsigned SCREEN_BASE = 16384;
  localparam int unsigned KBD_ADDR    = 24576;
  localparam int unsigned MEM_WORDS   = 24576;

  typedef enum logic [1:0] {REG_RAM, REG_SCREEN, REG_KBD, REG_ILLEGAL} region_e;

  typedef struct packed {
    logic [12:0] addr;
    logic [15:0] data;
  } scr_entry_t;

  function automatic region_e decode(input logic [14:0] addr,
                                     input int unsigned scr_base,
                                     input int unsigned kbd_addr);
    int unsigned a;
    a = 32'(addr);
    if (a < scr_base)       return REG_RAM;
    else if (a < kbd_addr)  return REG_SCREEN;
    else if (a == kbd_addr) return REG_KBD;
    else                    return REG_ILLEGAL;
  endfunction

endpackage

// File: rtl/screen_write_fifo.sv
// Synchronous FIFO carrying screen writes toward the display controller; DEPTH must be a power of two.
module screen_write_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 29
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [W-1:0]             data_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [AW:0]             level_q;
  logic                    do_push, do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      level_q <= level_q + 1'b1;
      else if (do_pop && !do_push) level_q <= level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/hack_memory_bus.sv
// Hack data-memory stage: RAM + screen shadow array, screen write FIFO, keyboard register.
// Optional sticky illegal-access flag enabled by defining HACK_BUS_ERROR_EN.
module hack_memory_bus #(
  parameter int          FIFO_DEPTH  = 4,
  parameter int unsigned SCREEN_BASE = hack_mem_pkg::SCREEN_BASE,
  parameter int unsigned KBD_ADDR    = hack_mem_pkg::KBD_ADDR
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [14:0]                   addressM,
  input  logic [15:0]                   outM,
  input  logic                          writeM,
  output logic [15:0]                   inM,
  output logic                          stall,
  output logic [12:0]                   scr_addr,
  output logic [15:0]                   scr_data,
  output logic                          scr_valid,
  input  logic                          scr_ready,
  input  logic [15:0]                   kbd_code,
  input  logic                          kbd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          bus_error
);
  import hack_mem_pkg::*;

  logic [15:0] mem [MEM_WORDS];
  logic [15:0] inM_q, inM_d, key_q;
  region_e     reg_s;
  logic        scr_wr, push, ram_we, fifo_full, fifo_empty;
  logic [12:0] scr_off;
  scr_entry_t  push_entry, head_entry;

  assign reg_s      = decode(addressM, SCREEN_BASE, KBD_ADDR);
  assign scr_wr     = writeM && (reg_s == REG_SCREEN);
  assign stall      = scr_wr && fifo_full;
  assign push       = scr_wr && !fifo_full;
  assign ram_we     = (writeM && (reg_s == REG_RAM)) || push;
  assign scr_off    = 13'(addressM - 15'(SCREEN_BASE));
  assign push_entry = '{addr: scr_off, data: outM};

  // A refused (stalled) screen write leaves both the shadow and FIFO untouched.
  always_ff @(posedge clk) begin
    if (ram_we) mem[addressM] <= outM;
  end

  always_comb begin
    inM_d = 16'h0000;
    case (reg_s)
      REG_RAM, REG_SCREEN: inM_d = ram_we ? outM : mem[addressM];
      REG_KBD:             inM_d = key_q;
      default:             inM_d = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inM_q <= '0;
      key_q <= '0;
    end else begin
      inM_q <= inM_d;
      if (kbd_valid) key_q <= kbd_code;
    end
  end

  assign inM = inM_q;

  screen_write_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(scr_entry_t))
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (scr_ready),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_o  (head_entry),
    .level_o (fifo_level)
  );

  assign scr_valid = !fifo_empty;
  assign scr_addr  = head_entry.addr;
  assign scr_data  = head_entry.data;

`ifdef HACK_BUS_ERROR_EN
  logic bus_err_q;
  // Every cycle is a read of addressM, so any illegal address sets the flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   bus_err_q <= 1'b0;
    else if (reg_s == REG_ILLEGAL)  bus_err_q <= 1'b1;
  end
  assign bus_error = bus_err_q;
`else
  assign bus_error = 1'b0;
`endif

endmodule

// File: tb/tb_hack_memory_bus.sv
// Directed self-checking bench for hack_memory_bus with FIFO_DEPTH=4.
module tb_hack_memory_bus;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [14:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] inM;
  logic        stall;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  logic        scr_valid;
  logic        scr_ready;
  logic [15:0] kbd_code;
  logic        kbd_valid;
  logic [2:0]  fifo_level;
  logic        bus_error;

  int checks = 0;
  int errors = 0;

`ifdef HACK_BUS_ERROR_EN
  localparam logic BERR_EXP = 1'b1;
`else
  localparam logic BERR_EXP = 1'b0;
`endif

  hack_memory_bus #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .addressM   (addressM),
    .outM       (outM),
    .writeM     (writeM),
    .inM        (inM),
    .stall      (stall),
    .scr_addr   (scr_addr),
    .scr_data   (scr_data),
    .scr_valid  (scr_valid),
    .scr_ready  (scr_ready),
    .kbd_code   (kbd_code),
    .kbd_valid  (kbd_valid),
    .fifo_level (fifo_level),
    .bus_error  (bus_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [14:0] a, input logic [15:0] d, input logic w);
    addressM = a;
    outM     = d;
    writeM   = w;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; addressM = '0; outM = '0; writeM = 1'b0;
    scr_ready = 1'b0; kbd_code = '0; kbd_valid = 1'b0;
    #12;
    chk("rst_inM", inM, 0);
    chk("rst_scr_valid", scr_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_bus_error", bus_error, 0);
    chk("rst_stall", stall, 0);
    reset_n = 1'b1;
    tick();

    // RAM write then read, and same-cycle write-first
    drive(15'd5, 16'h1234, 1'b1); tick();
    drive(15'd5, 16'h0000, 1'b0); tick();
    chk("ram_rd5", inM, 16'h1234);
    drive(15'd7, 16'hBEEF, 1'b1);
    chk("ram_nostall", stall, 0);
    tick();
    chk("ram_wf7", inM, 16'hBEEF);

    // screen write with display ready
    scr_ready = 1'b1;
    drive(15'd16384, 16'h00FF, 1'b1);
    chk("scr_nostall", stall, 0);
    tick();
    chk("scr_valid1", scr_valid, 1);
    chk("scr_addr0", scr_addr, 0);
    chk("scr_data0", scr_data, 16'h00FF);
    chk("scr_level1", fifo_level, 1);
    drive(15'd16484, 16'h5555, 1'b1); tick();
    drive(15'd16384, 16'h0000, 1'b0); tick();
    chk("scr_rd16384", inM, 16'h00FF);
    tick();
    chk("scr_drained", scr_valid, 0);

    // fill the FIFO with display stalled
    scr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(15'(16384 + i), 16'(16'hA000 + i), 1'b1); tick();
    end
    chk("full_level", fifo_level, 4);
    drive(15'd16484, 16'hDEAD, 1'b1);
    chk("full_stall", stall, 1);
    tick();
    chk("full_level_hold", fifo_level, 4);
    chk("full_not_stored", inM, 16'h5555);
    chk("full_head", scr_data, 16'hA000);

    // drain while the stalled write is held
    scr_ready = 1'b1; #1;
    chk("drain_stall_hi", stall, 1);
    chk("drain_addr0", scr_addr, 0);
    tick();
    chk("drain_level3", fifo_level, 3);
    chk("drain_stall_lo", stall, 0);
    chk("drain_data1", scr_data, 16'hA001);
    tick();
    chk("pushpop_level", fifo_level, 3);
    chk("pushpop_wf", inM, 16'hDEAD);
    drive(15'd0, 16'h0000, 1'b0);
    chk("drain_data2", scr_data, 16'hA002);
    chk("drain_addr2", scr_addr, 2);
    tick();
    chk("drain_data3", scr_data, 16'hA003);
    tick();
    chk("drain_dead_addr", scr_addr, 100);
    chk("drain_dead_data", scr_data, 16'hDEAD);
    tick();
    chk("drain_empty", scr_valid, 0);
    chk("drain_level0", fifo_level, 0);

    // keyboard register
    kbd_code = 16'h0084; kbd_valid = 1'b1; tick();
    kbd_valid = 1'b0; kbd_code = 16'h0000;
    drive(15'd24576, 16'h0000, 1'b0); tick();
    chk("kbd_rd", inM, 16'h0084);
    drive(15'd24576, 16'h1111, 1'b1);
    chk("kbd_wr_nostall", stall, 0);
    tick();
    drive(15'd24576, 16'h0000, 1'b0); tick();
    chk("kbd_wr_ignored", inM, 16'h0084);

    // illegal access
    drive(15'd30000, 16'h7777, 1'b1);
    chk("ill_nostall", stall, 0);
    tick();
    chk("ill_rd0", inM, 0);
    chk("ill_berr", bus_error, BERR_EXP);
    drive(15'd5, 16'h0000, 1'b0); tick();
    chk("ill_berr_sticky", bus_error, BERR_EXP);
    chk("ill_ram_intact", inM, 16'h1234);

    // reset mid-operation
    scr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(15'(16400 + i), 16'(16'hC000 + i), 1'b1); tick();
    end
    drive(15'd5, 16'h0000, 1'b0); tick();
    chk("pre_rst_level", fifo_level, 3);
    chk("pre_rst_inM", inM, 16'h1234);
    #2 reset_n = 1'b0; #1;
    chk("mid_rst_valid", scr_valid, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_inM", inM, 0);
    chk("mid_rst_berr", bus_error, 0);
    @(negedge clk); reset_n = 1'b1;
    tick();
    chk("post_rst_ram", inM, 16'h1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
